pts_scheduler: RTL and testbench
================================

Name: pts_scheduler

Overview:
- Round-robin scheduler that shares one 8-bit parallel-to-serial serializer among NUM_REQ byte requesters.
- Arbitrates pending requests and latches the winner's byte.
- Issues a one-cycle load to the serializer, then holds off further loads until the serializer reports completion.
- Enforces a programmable idle gap between frames.
- Sits between the byte producers and the serializer datapath.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: byte width; must equal the serializer input width.
- GAP_CYCLES, 2: idle cycles inserted after each ser_done (0 = no gap).
- TIMEOUT, 16: SHIFT-state watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held until acked.
- req_data  in  NUM_REQ*DATA_W  requester i's byte in bits [i*DATA_W +: DATA_W].
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse; the byte was taken.
- ser_load  out  1  one-cycle load strobe to the serializer.
- ser_data  out  DATA_W  byte presented to the serializer; valid when ser_load=1.
- ser_done  in  1  one-cycle pulse from the serializer after the last bit is shifted.
- grant_id  out  clog2(NUM_REQ)  index of the current owner; valid while active=1.
- active  out  1  high from LOAD through GAP.
- err_timeout  out  1  sticky watchdog flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (asynchronous, any state): all outputs 0, FSM=IDLE, gap counter 0, rr pointer = NUM_REQ-1 (so requester 0 wins first).
- FSM states: IDLE, LOAD, SHIFT, GAP. All outputs are registered.
- IDLE:
  - If any req_valid is high, select the first set bit searching from rr_ptr+1 upward with wrap.
  - Latch its data into ser_data, set grant_id, update rr_ptr to the winner, go to LOAD.
  - If no request is pending, stay in IDLE.
- LOAD (exactly one cycle): ser_load=1, req_ack[grant_id]=1, active=1; next state SHIFT.
- Latency: req_valid sampled high in IDLE at edge N gives ser_load and req_ack high during cycle N+1.
- Handshake: a requester holds req_valid and req_data stable until it sees req_ack. It may deassert or present a new byte in the cycle after the ack. Deasserting before the ack is legal; that request is simply not chosen.
- SHIFT:
  - ser_load=0; wait for ser_done.
  - On ser_done: go to GAP, loading the gap counter with GAP_CYCLES; if GAP_CYCLES=0, go directly to IDLE.
  - ser_done is ignored in IDLE, LOAD and GAP; no state change and no error.
- GAP: decrement the counter each cycle; go to IDLE when it reaches 1. Minimum spacing between ser_load pulses = serializer time + GAP_CYCLES + 2.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ frames. The current winner has the lowest priority in the next arbitration.
- Simultaneous events: new requests arriving during LOAD, SHIFT or GAP wait; they are evaluated only in IDLE.
- ser_data and grant_id hold their last values outside LOAD.
- Reset mid-frame: the scheduler drops the frame with no ack replay. The serializer shares rst and is reset with it.

Optional Feature:
- Macro: PTS_TIMEOUT_EN.
- Defined:
  - A SHIFT-state cycle counter aborts the frame if ser_done has not arrived after TIMEOUT cycles.
  - On abort: set sticky err_timeout, go to GAP as if ser_done had arrived.
  - err_timeout clears only on rst.
- Undefined: no counter; SHIFT waits indefinitely; err_timeout is constant 0.

Decomposition:
- Shared package pts_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_LOAD=2'd1, ST_SHIFT=2'd2, ST_GAP=2'd3.
  - DATA_W default.
  - clog2 helper function.
- One natural sub-module: pts_rr_arbiter.
  - Combinational rotate-priority pick taking req and rr_ptr; outputs a one-hot grant and an index.
- The FSM, latches and counters stay in pts_scheduler.

Test Plan:
- Single request: after rst deasserts, req_valid=4'b0100 with byte 8'h05 on lane 2 -> ser_load and req_ack=4'b0100 one cycle later, ser_data=8'h05, grant_id=2. Inject ser_done 8 cycles later -> active falls after 2 gap cycles.
- Round-robin: all four held valid with lane bytes 8'h03/8'h04/8'h07/8'h05 -> loads in order lane 0,1,2,3,0, each ack a single-cycle pulse.
- Back-pressure: req 1 raises during SHIFT of req 0 -> no load until ser_done plus GAP_CYCLES have elapsed; then lane 1 is loaded. Spacing checks equal 8+2+2 cycles with an 8-cycle serializer.
- Stray ser_done pulses in IDLE and GAP -> no state change, no ser_load.
- rst asserted asynchronously mid-SHIFT -> all outputs 0 immediately; first grant after release goes to lane 0.
- PTS_TIMEOUT_EN with TIMEOUT=16 and ser_done withheld -> err_timeout sets on the 16th SHIFT cycle, FSM returns to IDLE via GAP, and the flag stays set until rst.

Source files
------------

// File: rtl/pts_pkg.sv
// pts_pkg: definitions shared by the pts_scheduler slice.
//   - state_t     : scheduler FSM encoding (IDLE/LOAD/SHIFT/GAP)
//   - PTS_DATA_W  : default serializer byte width
//   - clog2()     : index-width helper; never returns less than 1 bit
package pts_pkg;

  localparam int PTS_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Width needed to index n items; a 1-item space still gets one bit so that
  // no vector ever collapses to zero width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pts_rr_arbiter.sv
// pts_rr_arbiter: combinational rotating-priority picker.
// The search starts at rr_ptr+1 and wraps, so the previous winner (rr_ptr)
// is considered last.
// Ports:
//   req    in   NUM_REQ  pending requests
//   rr_ptr in   IDX_W    index of the previous winner
//   grant  out  NUM_REQ  one-hot winner (all zero when nothing pending)
//   idx    out  IDX_W    winner index (0 when nothing pending)
//   any    out  1        at least one request pending
module pts_rr_arbiter
  import pts_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pts_scheduler.sv
// pts_scheduler: round-robin scheduler sharing one parallel-to-serial
// serializer among NUM_REQ byte requesters.
// Frame: IDLE (arbitrate, latch byte) -> LOAD (1-cycle strobe + ack)
//        -> SHIFT (wait ser_done) -> GAP (GAP_CYCLES idle) -> IDLE.
// Optional feature (macro PTS_TIMEOUT_EN): SHIFT watchdog that aborts a frame
// after TIMEOUT cycles without ser_done and sets sticky err_timeout.
// Without the macro err_timeout is tied 0 and SHIFT waits indefinitely.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   req_valid    per-requester request, held until acked
//   req_data     requester i byte in [i*DATA_W +: DATA_W]
//   req_ack      one-hot single-cycle pulse: byte taken
//   ser_load     single-cycle load strobe to the serializer
//   ser_data     byte for the serializer, valid with ser_load
//   ser_done     single-cycle pulse from the serializer at end of frame
//   grant_id     current owner index, valid while active
//   active       high from LOAD through GAP
//   err_timeout  sticky watchdog flag
module pts_scheduler
  import pts_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = PTS_DATA_W,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 16,
  localparam int IDX_W     = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      ser_load,
  output logic [DATA_W-1:0]         ser_data,
  input  logic                      ser_done,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      active,
  output logic                      err_timeout
);

  localparam int GAP_W = clog2(GAP_CYCLES + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("pts_scheduler: unsupported parameter combination");
  end

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [GAP_W-1:0]   gap_cnt;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               timeout_hit;
  logic               shift_exit;

  pts_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant),
    .idx    (arb_idx),
    .any    (arb_any)
  );

`ifdef PTS_TIMEOUT_EN
  localparam int TO_W = clog2(TIMEOUT);
  logic [TO_W-1:0] to_cnt;
  // to_cnt holds the number of SHIFT cycles already completed, so the abort
  // fires on the edge that ends the TIMEOUT-th SHIFT cycle.
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // ser_done wins over a simultaneous timeout: the frame completed normally.
  assign shift_exit = ser_done | timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Reset drops any frame in flight; the serializer is reset alongside.
      state    <= ST_IDLE;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      gap_cnt  <= '0;
      req_ack  <= '0;
      ser_load <= 1'b0;
      ser_data <= '0;
      grant_id <= '0;
      active   <= 1'b0;
`ifdef PTS_TIMEOUT_EN
      to_cnt      <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      // NOTE: state and outputs use non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      ser_load <= 1'b0;
      req_ack  <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            ser_data <= req_data[arb_idx*DATA_W +: DATA_W];
            grant_id <= arb_idx;
            rr_ptr   <= arb_idx;
            req_ack  <= arb_grant;
            ser_load <= 1'b1;
            active   <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_SHIFT;
`ifdef PTS_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        ST_SHIFT: begin
          if (shift_exit) begin
            if (GAP_CYCLES == 0) begin
              state  <= ST_IDLE;
              active <= 1'b0;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= GAP_W'(GAP_CYCLES);
            end
          end
`ifdef PTS_TIMEOUT_EN
          if (timeout_hit && !ser_done) err_timeout <= 1'b1;
          to_cnt <= to_cnt + 1'b1;
`endif
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            state  <= ST_IDLE;
            active <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pts_scheduler.sv
// tb_pts_scheduler: self-checking bench for pts_scheduler (NUM_REQ=4,
// DATA_W=8, GAP_CYCLES=2, TIMEOUT=16). Stimulus pushes the expected
// {lane, byte} of every load into a queue; a monitor pops and compares each
// time ser_load is seen. Timing properties are checked inline.
// The watchdog scenario runs only when PTS_TIMEOUT_EN is defined.
module tb_pts_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = 2;

  typedef struct {
    int          lane;
    logic [7:0]  data;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      ser_load;
  logic [DATA_W-1:0]         ser_data;
  logic                      ser_done = 1'b0;
  logic [IDX_W-1:0]          grant_id;
  logic                      active;
  logic                      err_timeout;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  pts_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .GAP_CYCLES(2), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .ser_load(ser_load), .ser_data(ser_data),
    .ser_done(ser_done), .grant_id(grant_id), .active(active),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int lane, input logic [7:0] data);
    exp_t e;
    e.lane = lane;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Bounded wait for the LOAD cycle; returns the cycle number it was seen in.
  task automatic wait_load(input string name, output int at);
    int n;
    n = 0;
    while (!ser_load && n < 50) begin
      tick(1);
      n++;
    end
    check({name, "_seen"}, 32'(ser_load), 32'd1);
    at = cyc;
  endtask

  // Called in SHIFT cycle 1: ser_done arrives in SHIFT cycle n.
  task automatic shift_done(input int n);
    tick(n - 1);
    ser_done = 1'b1;
    tick(1);
    ser_done = 1'b0;
  endtask

  // Scoreboard monitor: compares every load against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ser_load) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load: got lane %0d expected no load", grant_id);
        end else begin
          e = exp_q.pop_front();
          check("load_data", 32'(ser_data), 32'(e.data));
          check("load_grant", 32'(grant_id), 32'(e.lane));
          check("load_ack", 32'(req_ack), 32'(1 << e.lane));
        end
      end else if (req_ack != '0) begin
        errors++;
        $display("FAIL stray_ack: got %0h expected 0", req_ack);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t_req, t0, t1;

    // Reset state.
    tick(2);
    check("rst_ser_load", 32'(ser_load), 0);
    check("rst_req_ack", 32'(req_ack), 0);
    check("rst_ser_data", 32'(ser_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_active", 32'(active), 0);
    check("rst_err", 32'(err_timeout), 0);
    rst = 1'b0;

    // Single request on lane 2, 8-cycle serializer.
    req_valid = 4'b0100;
    req_data  = {8'h00, 8'h05, 8'h00, 8'h00};
    push(2, 8'h05);
    t_req = cyc;
    wait_load("single", t0);
    check("single_latency", 32'(t0 - t_req), 1);
    check("single_active_load", 32'(active), 1);
    tick(1);
    req_valid = '0;
    check("single_load_pulse", 32'(ser_load), 0);
    shift_done(8);
    check("single_gap1_active", 32'(active), 1);
    tick(1);
    check("single_gap2_active", 32'(active), 1);
    tick(1);
    check("single_idle_active", 32'(active), 0);
    check("single_hold_data", 32'(ser_data), 32'h05);
    check("single_hold_grant", 32'(grant_id), 2);

    // Stray ser_done in IDLE.
    ser_done = 1'b1;
    tick(1);
    ser_done = 1'b0;
    check("stray_idle_active", 32'(active), 0);
    tick(1);
    check("stray_idle_load", 32'(ser_load), 0);

    // Round robin from fresh reset: lanes 0,1,2,3,0.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req_data  = {8'h05, 8'h07, 8'h04, 8'h03};
    req_valid = 4'b1111;
    push(0, 8'h03); push(1, 8'h04); push(2, 8'h07); push(3, 8'h05); push(0, 8'h03);
    for (int i = 0; i < 5; i++) begin
      wait_load("rr", t0);
      tick(1);
      if (i == 4) req_valid = '0;
      shift_done(4);
      tick(2);
    end

    // Back-pressure: lane 1 raises during lane 0's SHIFT; spacing 8+2+2.
    req_valid = 4'b0001;
    req_data  = {8'h00, 8'h00, 8'hB2, 8'hA1};
    push(0, 8'hA1);
    wait_load("bp0", t0);
    tick(1);
    req_valid = 4'b0010;
    push(1, 8'hB2);
    shift_done(8);
    check("bp_gap_no_load", 32'(ser_load), 0);
    tick(2);
    check("bp_idle_no_load", 32'(ser_load), 0);
    wait_load("bp1", t1);
    check("bp_spacing", 32'(t1 - t0), 12);

    // Stray ser_done during LOAD and during GAP are ignored.
    ser_done = 1'b1;
    tick(1);
    ser_done  = 1'b0;
    req_valid = '0;
    tick(3);
    check("stray_load_active", 32'(active), 1);
    ser_done = 1'b1;
    tick(1);
    tick(1);
    ser_done = 1'b0;
    check("stray_gap_active", 32'(active), 1);
    tick(1);
    check("stray_gap_idle", 32'(active), 0);

    // Asynchronous reset mid-SHIFT.
    req_valid = 4'b0100;
    req_data  = {8'h00, 8'h5C, 8'h00, 8'h00};
    push(2, 8'h5C);
    wait_load("mid", t0);
    tick(1);
    req_valid = '0;
    tick(2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_active", 32'(active), 0);
    check("mid_rst_load", 32'(ser_load), 0);
    check("mid_rst_ack", 32'(req_ack), 0);
    check("mid_rst_data", 32'(ser_data), 0);
    check("mid_rst_grant", 32'(grant_id), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'b1001;
    req_data  = {8'h33, 8'h00, 8'h00, 8'h11};
    push(0, 8'h11); push(3, 8'h33);
    wait_load("post_rst0", t0);
    tick(1);
    req_valid = 4'b1000;
    shift_done(4);
    tick(2);
    wait_load("post_rst1", t0);
    tick(1);
    req_valid = '0;
    shift_done(4);
    tick(2);

`ifdef PTS_TIMEOUT_EN
    // Watchdog: ser_done withheld, abort on the 16th SHIFT cycle.
    req_valid = 4'b0010;
    req_data  = {8'h00, 8'h00, 8'h42, 8'h00};
    push(1, 8'h42);
    wait_load("to", t0);
    tick(1);
    req_valid = '0;
    tick(15);
    check("to_before", 32'(err_timeout), 0);
    check("to_shift16_active", 32'(active), 1);
    tick(1);
    check("to_set", 32'(err_timeout), 1);
    check("to_gap_active", 32'(active), 1);
    tick(2);
    check("to_idle_active", 32'(active), 0);
    tick(3);
    check("to_sticky", 32'(err_timeout), 1);
    rst = 1'b1;
    #1;
    check("to_rst_clear", 32'(err_timeout), 0);
    tick(1);
    rst = 1'b0;
`else
    check("no_to_err", 32'(err_timeout), 0);
`endif

    tick(2);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
